// File: rtl/window_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : window_scan_sequencer
// Description : Walks every valid 3x3 window centre of an image in raster
//               order. It issues pixel reads to fill the window register,
//               triggers the gradient calculation and then issues the
//               edge-result write for each window.
// Revision    : 1.0 - initial release
// ============================================================================
module window_scan_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_slot,
    input  logic              rd_done,
    output logic              win_shift,
    output logic              calc_start,
    input  logic              calc_done,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_done
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CHECK     = 4'd1,
        FULL_RD   = 4'd2,
        SHIFT     = 4'd3,
        SHIFT_RD  = 4'd4,
        CALC      = 4'd5,
        CALC_WAIT = 4'd6,
        WRITE     = 4'd7,
        ADVANCE   = 4'd8,
        DONE      = 4'd9
    } state_t;

    state_t            state;

    // Parameters captured when a start is accepted.
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;

    // Current window centre and address of its top-left pixel. Tracking the
    // top-left address incrementally avoids a row*width multiply.
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic [ADDR_W-1:0] win_base;

    // Row stride expressed in the address domain.
    logic [ADDR_W-1:0] stride;
    assign stride = ADDR_W'(width);

    // Window scan state machine with all outputs registered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            width      <= '0;
            height     <= '0;
            src        <= '0;
            dst        <= '0;
            row        <= '0;
            col        <= '0;
            win_base   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            rd_slot    <= 4'd0;
            win_shift  <= 1'b0;
            calc_start <= 1'b0;
            wr_req     <= 1'b0;
            wr_addr    <= '0;
        end else begin
            // Pulse outputs last a single cycle unless re-armed below.
            done       <= 1'b0;
            win_shift  <= 1'b0;
            calc_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        width  <= img_width;
                        height <= img_height;
                        src    <= src_base;
                        dst    <= dst_base;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end

                CHECK: begin
                    if ((width < DIM_W'(3)) || (height < DIM_W'(3))) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        row      <= DIM_W'(1);
                        col      <= DIM_W'(1);
                        win_base <= src;
                        wr_addr  <= dst;
                        rd_req   <= 1'b1;
                        rd_addr  <= src;
                        rd_slot  <= 4'd0;
                        state    <= FULL_RD;
                    end
                end

                FULL_RD: begin
                    if (rd_done) begin
                        if (rd_slot == 4'd8) begin
                            rd_req     <= 1'b0;
                            calc_start <= 1'b1;
                            state      <= CALC;
                        end else begin
                            rd_slot <= rd_slot + 4'd1;
                            // Slots 2 and 5 end a window row: wrap to the
                            // left column of the next image row.
                            if ((rd_slot == 4'd2) || (rd_slot == 4'd5)) begin
                                rd_addr <= rd_addr + stride - ADDR_W'(2);
                            end else begin
                                rd_addr <= rd_addr + ADDR_W'(1);
                            end
                        end
                    end
                end

                SHIFT: begin
                    // New right-hand column sits two pixels right of the
                    // (already advanced) top-left corner.
                    rd_req  <= 1'b1;
                    rd_addr <= win_base + ADDR_W'(2);
                    rd_slot <= 4'd2;
                    state   <= SHIFT_RD;
                end

                SHIFT_RD: begin
                    if (rd_done) begin
                        if (rd_slot == 4'd8) begin
                            rd_req     <= 1'b0;
                            calc_start <= 1'b1;
                            state      <= CALC;
                        end else begin
                            rd_slot <= rd_slot + 4'd3;
                            rd_addr <= rd_addr + stride;
                        end
                    end
                end

                CALC: begin
                    state <= CALC_WAIT;
                end

                CALC_WAIT: begin
                    if (calc_done) begin
                        wr_req <= 1'b1;
                        state  <= WRITE;
                    end
                end

                WRITE: begin
                    if (wr_done) begin
                        wr_req <= 1'b0;
                        state  <= ADVANCE;
                    end
                end

                ADVANCE: begin
                    if (col < (width - DIM_W'(2))) begin
                        col       <= col + DIM_W'(1);
                        win_base  <= win_base + ADDR_W'(1);
                        wr_addr   <= wr_addr + ADDR_W'(1);
                        win_shift <= 1'b1;
                        state     <= SHIFT;
                    end else if (row < (height - DIM_W'(2))) begin
                        // Last window of a row has its top-left at column
                        // W-3, so the next row start is three pixels on.
                        row      <= row + DIM_W'(1);
                        col      <= DIM_W'(1);
                        win_base <= win_base + ADDR_W'(3);
                        wr_addr  <= wr_addr + ADDR_W'(1);
                        rd_req   <= 1'b1;
                        rd_addr  <= win_base + ADDR_W'(3);
                        rd_slot  <= 4'd0;
                        state    <= FULL_RD;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy   <= 1'b0;
                    rd_req <= 1'b0;
                    wr_req <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_scan_sequencer
// Description : Self-checking bench for window_scan_sequencer. An event-list
//               model of the scan is compared against the DUT every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_scan_sequencer;

    localparam int ADDR_W = 16;
    localparam int DIM_W  = 10;

    logic              clk        = 1'b0;
    logic              n_rst      = 1'b0;
    logic              start      = 1'b0;
    logic [DIM_W-1:0]  img_width  = '0;
    logic [DIM_W-1:0]  img_height = '0;
    logic [ADDR_W-1:0] src_base   = '0;
    logic [ADDR_W-1:0] dst_base   = '0;
    logic              rd_done    = 1'b0;
    logic              calc_done  = 1'b0;
    logic              wr_done    = 1'b0;
    logic              busy;
    logic              done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        rd_slot;
    logic              win_shift;
    logic              calc_start;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;

    window_scan_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .img_width(img_width), .img_height(img_height),
        .src_base(src_base), .dst_base(dst_base),
        .busy(busy), .done(done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_slot(rd_slot), .rd_done(rd_done),
        .win_shift(win_shift), .calc_start(calc_start), .calc_done(calc_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {EV_READ, EV_SHIFT, EV_CALC, EV_WRITE, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        slot;
    } ev_t;

    ev_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    bit active = 1'b0;
    bit start_next = 1'b0;
    int rd_delay = 0;
    int wr_delay = 0;
    int rd_wait = 0;
    int wr_wait = 0;
    bit calc_pend = 1'b0;

    bit                prev_rd_req = 1'b0, prev_rd_done = 1'b0;
    bit                prev_wr_req = 1'b0, prev_wr_done = 1'b0;
    logic [ADDR_W-1:0] prev_rd_addr = '0, prev_wr_addr = '0;
    logic [3:0]        prev_rd_slot = '0;

    int rd_log_addr[$];
    int rd_log_slot[$];
    int wr_log[$];
    int calc_cnt = 0, shift_cnt = 0, done_cnt = 0;
    int first_rd_rel = -1, calc_rel = -1, wr_rel = -1, done_rel = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected event stream for one image, straight from the raster rules.
    task automatic model_load(input int w, input int h, input int src, input int dst);
        ev_t e;
        exp_q.delete();
        if (w >= 3 && h >= 3) begin
            for (int r = 1; r <= h - 2; r++) begin
                for (int c = 1; c <= w - 2; c++) begin
                    if (c == 1) begin
                        for (int k = 0; k < 9; k++) begin
                            e.kind = EV_READ;
                            e.addr = ADDR_W'(src + (r - 1 + k / 3) * w + (c - 1 + k % 3));
                            e.slot = 4'(k);
                            exp_q.push_back(e);
                        end
                    end else begin
                        e.kind = EV_SHIFT; e.addr = '0; e.slot = '0;
                        exp_q.push_back(e);
                        for (int k = 0; k < 3; k++) begin
                            e.kind = EV_READ;
                            e.addr = ADDR_W'(src + (r - 1 + k) * w + (c + 1));
                            e.slot = 4'(3 * k + 2);
                            exp_q.push_back(e);
                        end
                    end
                    e.kind = EV_CALC; e.addr = '0; e.slot = '0;
                    exp_q.push_back(e);
                    e.kind = EV_WRITE;
                    e.addr = ADDR_W'(dst + (r - 1) * (w - 2) + (c - 1));
                    e.slot = '0;
                    exp_q.push_back(e);
                end
            end
        end
        e.kind = EV_DONE; e.addr = '0; e.slot = '0;
        exp_q.push_back(e);
    endtask

    task automatic expect_event(input ev_kind_t kind, input logic [ADDR_W-1:0] addr,
                                input logic [3:0] slot);
        ev_t e;
        bit  bad;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event_order: actual kind=%s addr=0x%0h slot=%0d required=no event (cycle %0d)",
                     kind.name(), addr, slot, cyc);
        end else begin
            e = exp_q.pop_front();
            bad = (e.kind != kind) ||
                  ((kind == EV_READ)  && ((e.addr != addr) || (e.slot != slot))) ||
                  ((kind == EV_WRITE) && (e.addr != addr));
            if (bad) begin
                fails++;
                $display("FAIL event_order: actual kind=%s addr=0x%0h slot=%0d required kind=%s addr=0x%0h slot=%0d (cycle %0d)",
                         kind.name(), addr, slot, e.kind.name(), e.addr, e.slot, cyc);
            end
        end
    endtask

    // One clock cycle: respond to handshakes, compare outputs, apply start.
    task automatic tick();
        bit rd_fire;
        bit wr_fire;
        @(negedge clk);
        cyc++;
        if (rd_req) begin
            rd_done = (rd_wait >= rd_delay);
            rd_wait = rd_done ? 0 : rd_wait + 1;
        end else begin
            rd_done = 1'b0;
            rd_wait = 0;
        end
        if (wr_req) begin
            wr_done = (wr_wait >= wr_delay);
            wr_wait = wr_done ? 0 : wr_wait + 1;
        end else begin
            wr_done = 1'b0;
            wr_wait = 0;
        end
        calc_done = calc_pend;
        calc_pend = 1'b0;
        rd_fire = rd_req & rd_done;
        wr_fire = wr_req & wr_done;

        if (!n_rst) begin
            check("reset_outputs_zero",
                  32'(|{busy, done, rd_req, rd_addr, rd_slot, win_shift, calc_start, wr_req, wr_addr}), 32'd0);
            prev_rd_req = 1'b0; prev_rd_done = 1'b0;
            prev_wr_req = 1'b0; prev_wr_done = 1'b0;
        end else begin
            check("busy", 32'(busy), 32'(active && (cyc > t0)));
            if (!active) begin
                check("idle_outputs", 32'({rd_req, wr_req, calc_start, win_shift, done}), 32'd0);
            end else begin
                if (rd_req && prev_rd_req && !prev_rd_done) begin
                    check("rd_addr_hold", 32'(rd_addr), 32'(prev_rd_addr));
                    check("rd_slot_hold", 32'(rd_slot), 32'(prev_rd_slot));
                end
                if (prev_rd_req && prev_rd_done)
                    check("rd_req_after_read", 32'(rd_req),
                          32'((exp_q.size() > 0) && (exp_q[0].kind == EV_READ)));
                if (wr_req && prev_wr_req && !prev_wr_done)
                    check("wr_addr_hold", 32'(wr_addr), 32'(prev_wr_addr));
                if (prev_wr_req && prev_wr_done)
                    check("wr_req_drop", 32'(wr_req), 32'd0);
                if (rd_req && first_rd_rel < 0) first_rd_rel = cyc - t0;
                if (wr_req && wr_rel < 0) wr_rel = cyc - t0;
                if (rd_fire) begin
                    expect_event(EV_READ, rd_addr, rd_slot);
                    rd_log_addr.push_back(int'(rd_addr));
                    rd_log_slot.push_back(int'(rd_slot));
                end
                if (win_shift) begin
                    expect_event(EV_SHIFT, '0, '0);
                    shift_cnt++;
                end
                if (calc_start) begin
                    expect_event(EV_CALC, '0, '0);
                    calc_pend = 1'b1;
                    calc_cnt++;
                    if (calc_rel < 0) calc_rel = cyc - t0;
                end
                if (wr_fire) begin
                    expect_event(EV_WRITE, wr_addr, '0);
                    wr_log.push_back(int'(wr_addr));
                end
                if (done) begin
                    expect_event(EV_DONE, '0, '0);
                    done_rel = cyc - t0;
                    active = 1'b0;
                end
            end
            if (done) done_cnt++;
            prev_rd_req = rd_req; prev_rd_done = rd_done;
            prev_rd_addr = rd_addr; prev_rd_slot = rd_slot;
            prev_wr_req = wr_req; prev_wr_done = wr_done;
            prev_wr_addr = wr_addr;
        end

        start = start_next;
        if (start_next && n_rst && !busy && !active) begin
            active = 1'b1;
            t0 = cyc;
            first_rd_rel = -1; calc_rel = -1; wr_rel = -1; done_rel = -1;
            model_load(int'(img_width), int'(img_height), int'(src_base), int'(dst_base));
        end
    endtask

    task automatic launch(input int w, input int h, input int src, input int dst);
        img_width  = DIM_W'(w);
        img_height = DIM_W'(h);
        src_base   = ADDR_W'(src);
        dst_base   = ADDR_W'(dst);
        start_next = 1'b1;
        tick();
        start_next = 1'b0;
    endtask

    task automatic abort_model();
        active = 1'b0;
        calc_pend = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && active; i++) tick();
        check("image_completes", 32'(active), 32'd0);
        if (active) begin
            n_rst = 1'b0;
            abort_model();
            tick();
            n_rst = 1'b1;
        end
        check("model_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, wb, db, cb, sb;

        // Reset state.
        n_rst = 1'b0;
        repeat (3) tick();
        n_rst = 1'b1;
        repeat (2) tick();

        // 3x3 zero-wait image.
        rb = rd_log_addr.size(); wb = wr_log.size();
        launch(3, 3, 16'h0000, 16'h0100);
        wait_done(100);
        check("t1_first_rd_cycle", 32'(first_rd_rel), 32'd2);
        check("t1_calc_cycle", 32'(calc_rel), 32'd11);
        check("t1_wr_cycle", 32'(wr_rel), 32'd13);
        check("t1_done_cycle", 32'(done_rel), 32'd15);
        check("t1_read_count", 32'(rd_log_addr.size() - rb), 32'd9);
        if (rd_log_addr.size() - rb == 9) begin
            for (int k = 0; k < 9; k++) begin
                check("t1_read_addr", 32'(rd_log_addr[rb + k]), 32'(k));
                check("t1_read_slot", 32'(rd_log_slot[rb + k]), 32'(k));
            end
        end
        check("t1_write_count", 32'(wr_log.size() - wb), 32'd1);
        if (wr_log.size() > wb) check("t1_write_addr", 32'(wr_log[wb]), 32'h0100);

        // 4x4 image with column shifts.
        rb = rd_log_addr.size(); wb = wr_log.size(); sb = shift_cnt;
        launch(4, 4, 16'h0010, 16'h0200);
        wait_done(200);
        check("t2_read_count", 32'(rd_log_addr.size() - rb), 32'd24);
        check("t2_shift_count", 32'(shift_cnt - sb), 32'd2);
        if (rd_log_addr.size() - rb >= 12) begin
            check("t2_shift_rd0_addr", 32'(rd_log_addr[rb + 9]), 32'h0013);
            check("t2_shift_rd1_addr", 32'(rd_log_addr[rb + 10]), 32'h0017);
            check("t2_shift_rd2_addr", 32'(rd_log_addr[rb + 11]), 32'h001B);
            check("t2_shift_rd0_slot", 32'(rd_log_slot[rb + 9]), 32'd2);
            check("t2_shift_rd1_slot", 32'(rd_log_slot[rb + 10]), 32'd5);
            check("t2_shift_rd2_slot", 32'(rd_log_slot[rb + 11]), 32'd8);
        end
        check("t2_write_count", 32'(wr_log.size() - wb), 32'd4);
        if (wr_log.size() - wb == 4) begin
            for (int k = 0; k < 4; k++)
                check("t2_write_addr", 32'(wr_log[wb + k]), 32'(32'h0200 + k));
        end

        // Degenerate W=2, H=5.
        rb = rd_log_addr.size(); wb = wr_log.size(); cb = calc_cnt;
        launch(2, 5, 16'h0000, 16'h0000);
        wait_done(20);
        check("t3_done_cycle", 32'(done_rel), 32'd2);
        check("t3_no_rd_req", 32'(first_rd_rel < 0), 32'd1);
        check("t3_no_wr_req", 32'(wr_rel < 0), 32'd1);
        check("t3_no_calc", 32'(calc_cnt - cb), 32'd0);

        // Slow reads plus an ignored start mid-image.
        rd_delay = 3;
        rb = rd_log_addr.size(); wb = wr_log.size(); db = done_cnt;
        launch(5, 4, 16'h0040, 16'h0300);
        repeat (20) tick();
        img_width = DIM_W'(3); img_height = DIM_W'(3);
        src_base = 16'h0000; dst_base = 16'h0000;
        start_next = 1'b1;
        tick();
        start_next = 1'b0;
        wait_done(800);
        check("t4_read_count", 32'(rd_log_addr.size() - rb), 32'd30);
        check("t4_write_count", 32'(wr_log.size() - wb), 32'd6);
        if (wr_log.size() - wb == 6) check("t4_last_write", 32'(wr_log[wb + 5]), 32'h0305);
        check("t4_done_pulses", 32'(done_cnt - db), 32'd1);
        repeat (5) tick();
        check("t4_no_restart", 32'(done_cnt - db), 32'd1);

        // Asynchronous reset during FULL_RD slot 4.
        rd_delay = 1;
        db = done_cnt;
        launch(3, 3, 16'h0020, 16'h0400);
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 60 && !found; i++) begin
                tick();
                if (rd_req && rd_slot == 4'd4) found = 1'b1;
            end
            check("t5_reached_slot4", 32'(found), 32'd1);
        end
        n_rst = 1'b0;
        #1;
        check("t5_async_clear",
              32'(|{busy, done, rd_req, rd_addr, rd_slot, win_shift, calc_start, wr_req, wr_addr}), 32'd0);
        abort_model();
        repeat (2) tick();
        n_rst = 1'b1;
        repeat (2) tick();
        check("t5_no_done_on_abort", 32'(done_cnt - db), 32'd0);
        rd_delay = 0;
        rb = rd_log_addr.size();
        launch(3, 3, 16'h0020, 16'h0400);
        wait_done(100);
        if (rd_log_addr.size() > rb) begin
            check("t5_restart_addr", 32'(rd_log_addr[rb]), 32'h0020);
            check("t5_restart_slot", 32'(rd_log_slot[rb]), 32'd0);
        end else begin
            check("t5_restart_reads", 32'(rd_log_addr.size() - rb), 32'd9);
        end
        check("t5_done_after_restart", 32'(done_cnt - db), 32'd1);

        // Address wrap.
        rb = rd_log_addr.size();
        launch(3, 3, 16'hFFFE, 16'h0000);
        wait_done(100);
        check("t6_read_count", 32'(rd_log_addr.size() - rb), 32'd9);
        if (rd_log_addr.size() - rb == 9) begin
            check("t6_rd0", 32'(rd_log_addr[rb + 0]), 32'hFFFE);
            check("t6_rd1", 32'(rd_log_addr[rb + 1]), 32'hFFFF);
            check("t6_rd2", 32'(rd_log_addr[rb + 2]), 32'h0000);
            check("t6_rd8", 32'(rd_log_addr[rb + 8]), 32'h0006);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
